// File: rtl/if_pc_btb.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit saturating predictors.
// Branch prediction storage exists only when IF_BRANCH_PRED_EN is defined; otherwise static not-taken.
module if_pc_btb #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fStall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_upd,
  input  logic [31:0] ex_upd_pc,
  input  logic        ex_upd_taken,
  input  logic [31:0] ex_upd_target,
  output logic [31:0] pc_f,
  output logic        br_pred_f,
  output logic [31:0] pc_next
);

  logic [31:0] pc_q;
  logic [31:0] pred_pc;

  assign pc_f = pc_q;

`ifdef IF_BRANCH_PRED_EN
  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
  logic [29:0]            tgt_q [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];

  logic [IDX-1:0]  l_idx, u_idx;
  logic [TAGW-1:0] l_tag, u_tag;
  logic            l_hit, u_hit;
  logic            unused_lo;

  assign l_idx = pc_q[IDX+1:2];
  assign l_tag = pc_q[31:IDX+2];
  assign u_idx = ex_upd_pc[IDX+1:2];
  assign u_tag = ex_upd_pc[31:IDX+2];

  assign l_hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign br_pred_f = l_hit && ctr_q[l_idx][1];
  assign pred_pc   = br_pred_f ? {tgt_q[l_idx], 2'b00} : pc_q + 32'd4;

  // Low address bits are not stored; targets are kept word-aligned.
  assign unused_lo = ^{ex_upd_pc[1:0], ex_upd_target[1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (ex_upd) begin
      if (u_hit) begin
        if (ex_upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          tgt_q[u_idx] <= ex_upd_target[31:2];
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (ex_upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= ex_upd_target[31:2];
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end
`else
  logic unused_ex;

  assign br_pred_f = 1'b0;
  assign pred_pc   = pc_q + 32'd4;
  assign unused_ex = ^{ex_upd, ex_upd_pc, ex_upd_taken, ex_upd_target, BTB_ENTRIES[0]};
`endif

  always_comb begin
    pc_next = pred_pc;
    if (ex_redirect)  pc_next = ex_redirect_pc;
    else if (fStall)  pc_next = pc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_PC;
    else       pc_q <= pc_next;
  end

endmodule
